// File: rtl/icache_pkg.sv
// Shared defaults, derived widths and state encoding for the instruction cache.
package icache_pkg;

  localparam int ICACHE_INDEX_BITS  = 4;
  localparam int ICACHE_OFFSET_BITS = 2;
  localparam int ICACHE_TAG_BITS    = 32 - ICACHE_INDEX_BITS - ICACHE_OFFSET_BITS - 2;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

  // Tag width left over once index, word offset and byte offset are removed.
  function automatic int icache_tag_bits(input int index_bits, input int offset_bits);
    return 30 - index_bits - offset_bits;
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Data and tag storage for the instruction cache, kept apart so it can map to RAM.
// Synchronous writes, combinational reads, no reset.
module icache_data_array #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 24
) (
  input  logic                   clk,
  input  logic                   data_we,
  input  logic                   tag_we,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_word,
  input  logic [31:0]            wr_data,
  input  logic [TAG_BITS-1:0]    wr_tag,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_word,
  output logic [31:0]            rd_data,
  output logic [TAG_BITS-1:0]    rd_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  logic [31:0]         data_mem [LINES][WORDS];
  logic [TAG_BITS-1:0] tag_mem  [LINES];

  // Write one refill word and, on the last word, the line tag.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[wr_index][wr_word] <= wr_data;
    if (tag_we)  tag_mem[wr_index] <= wr_tag;
  end

  // Asynchronous read for the same-cycle lookup.
  always_comb begin
    rd_data = data_mem[rd_index][rd_word];
    rd_tag  = tag_mem[rd_index];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational lookup, whole-line refill from
// the memory controller one word per mem_done, hit-under-miss on other lines.
//
// state         | meaning
// ICACHE_IDLE   | serving hits; a miss launches a refill of the missing line
// ICACHE_REFILL | requesting line words 0..last; pc changes ignored until done
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc,
  output logic        icache_hit,
  output logic [31:0] icache_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int TAG_BITS = icache_tag_bits(INDEX_BITS, OFFSET_BITS);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int LO       = OFFSET_BITS + 2;

  logic [TAG_BITS-1:0]    pc_tag;
  logic [INDEX_BITS-1:0]  pc_index;
  logic [OFFSET_BITS-1:0] pc_word;
  logic                   unused_pc_bits;

  icache_state_e          state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   mem_req_q, mem_req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0]  miss_index_q, miss_index_d;

  logic                   data_we;
  logic                   tag_we;
  logic [31:0]            rd_data;
  logic [TAG_BITS-1:0]    rd_tag;

  assign pc_tag         = pc[31:INDEX_BITS+LO];
  assign pc_index       = pc[INDEX_BITS+LO-1:LO];
  assign pc_word        = pc[LO-1:2];
  assign unused_pc_bits = ^pc[1:0];

  icache_data_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_data_array (
    .clk     (clk),
    .data_we (data_we),
    .tag_we  (tag_we),
    .wr_index(miss_index_q),
    .wr_word (cnt_q),
    .wr_data (mem_data),
    .wr_tag  (miss_tag_q),
    .rd_index(pc_index),
    .rd_word (pc_word),
    .rd_data (rd_data),
    .rd_tag  (rd_tag)
  );

  // Lookup runs in both states; the refilling line is invalid so it never hits.
  always_comb begin
    icache_hit  = valid_q[pc_index] && (rd_tag == pc_tag);
    icache_inst = rd_data;
  end

  // Next-state logic; nothing moves while rdy is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    valid_d      = valid_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    if (rdy) begin
      case (state_q)
        ICACHE_IDLE: begin
          if (!icache_hit) begin
            miss_tag_d        = pc_tag;
            miss_index_d      = pc_index;
            valid_d[pc_index] = 1'b0;
            cnt_d             = '0;
            mem_addr_d        = {pc[31:LO], {LO{1'b0}}};
            mem_req_d         = 1'b1;
            state_d           = ICACHE_REFILL;
          end
        end
        ICACHE_REFILL: begin
          if (mem_done) begin
            data_we = 1'b1;
            if (cnt_q == {OFFSET_BITS{1'b1}}) begin
              tag_we                = 1'b1;
              valid_d[miss_index_q] = 1'b1;
              mem_req_d             = 1'b0;
              cnt_d                 = '0;
              state_d               = ICACHE_IDLE;
            end else begin
              cnt_d      = cnt_q + 1'b1;
              mem_addr_d = mem_addr_q + 32'd4;
            end
          end
        end
        default: state_d = ICACHE_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset invalidates every line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ICACHE_IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      valid_q      <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      valid_q      <= valid_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule
